fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned     DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: alloc reserves a slot at request time, fill writes the
// returning instruction, pop frees the head once decode takes it.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [XLEN-1:0]  alloc_pc_i,
  input  logic             fill_i,
  input  logic [XLEN-1:0]  fill_instr_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] count_c,
  output logic [PTR_W-1:0] outstanding_c,
  output fetch_entry_t     head_c
);

  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] read_ptr;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] read_idx;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  assign alloc_idx     = alloc_ptr[IDX_W-1:0];
  assign fill_idx      = fill_ptr[IDX_W-1:0];
  assign read_idx      = read_ptr[IDX_W-1:0];
  assign count_c       = alloc_ptr - read_ptr;
  assign outstanding_c = alloc_ptr - fill_ptr;
  assign head_c        = '{pc: pc_q[read_idx], instr: instr_q[read_idx], filled: filled_q[read_idx]};

  // Pointers and valid bits; a flush drops every entry at once.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled_q  <= '0;
    end else begin
      if (alloc_i) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
      end
      if (fill_i) begin
        filled_q[fill_idx] <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_W'(1);
      end
      if (pop_i) begin
        filled_q[read_idx] <= 1'b0;
        read_ptr           <= read_ptr + PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset; filled_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (alloc_i) begin
      pc_q[alloc_idx] <= alloc_pc_i;
    end
    if (fill_i) begin
      instr_q[fill_idx] <= fill_instr_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches, queues responses for
// decode, and discards in-flight responses that a redirect made stale.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] drop_cnt;
  logic [PTR_W-1:0] count_c;
  logic [PTR_W-1:0] outstanding_c;
  fetch_entry_t     head_c;
  logic [SUM_W-1:0] occupancy;
  logic             req_fire;
  logic             rsp_hit;
  logic             rsp_fill;
  logic             pop;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Stale responses still hold memory slots, so they count against the queue depth.
  always_comb begin
    occupancy        = SUM_W'(count_c) + SUM_W'(drop_cnt);
    imem_req_valid_o = !rst_i && !redirect_i && (occupancy < SUM_W'(DEPTH));
    imem_req_addr_o  = fetch_pc;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_hit          = imem_rsp_valid_i && ((drop_cnt != '0) || (outstanding_c != '0));
    rsp_fill         = rsp_hit && !rst_i && !redirect_i && (drop_cnt == '0);
    id_valid_o       = !rst_i && !redirect_i && head_c.filled;
    id_pc_o          = head_c.pc;
    id_instr_o       = head_c.instr;
    pop              = id_valid_o && id_ready_i;
  end

  // A response landing in a redirect cycle retires one in-flight request itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_cnt <= drop_cnt + outstanding_c - PTR_W'(rsp_hit);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (imem_rsp_valid_i && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && imem_rsp_valid_i) begin
      assert ((drop_cnt != '0) || (outstanding_c != '0))
        else $error("fetch_unit: response with no outstanding request");
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (redirect_i),
    .alloc_i       (req_fire),
    .alloc_pc_i    (fetch_pc),
    .fill_i        (rsp_fill),
    .fill_instr_i  (imem_rsp_data_i),
    .pop_i         (pop),
    .count_c       (count_c),
    .outstanding_c (outstanding_c),
    .head_c        (head_c)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a request/epoch model of memory and the decode stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; bit got; } live_t;

  logic        clk = 1'b0;
  logic        rst, req_ready, rsp_valid, redirect, id_ready;
  logic [31:0] rsp_data, redirect_pc;
  logic        req_valid, id_valid;
  logic [31:0] req_addr, id_pc, id_instr;
  logic        w_req_valid, w_id_valid;
  logic [31:0] w_req_addr, unused_w_id_pc, unused_w_id_instr;

  mreq_t       pend[$];
  live_t       live_q[$];
  logic [31:0] req_log[$], pop_log[$], pop_cyc[$], w_log[$];
  int          checks = 0, errors = 0, cyc = 0, epoch = 0, lat = 1, w_n = 0;
  int          n0, p0;
  logic [31:0] exp_req_pc, w_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_pc_o(id_pc), .id_instr_o(id_instr)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(1'b1), .imem_req_addr_o(w_req_addr),
    .imem_rsp_valid_i(1'b0), .imem_rsp_data_i(32'h0),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .id_valid_o(w_id_valid), .id_ready_i(1'b1), .id_pc_o(unused_w_id_pc), .id_instr_o(unused_w_id_instr)
  );

  // Memory contents: odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, check outputs, advance the model across the edge.
  task automatic step();
    bit    exp_req_v, exp_id_v, exp_w_v;
    mreq_t r;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend[0].addr);
    end
    #1;
    exp_req_v = !rst && !redirect && (live_q.size() + stale_cnt() < DEPTH);
    exp_id_v  = !rst && !redirect && live_q.size() > 0 && live_q[0].got;
    exp_w_v   = !rst && (w_n < DEPTH);
    chk("req_valid", 32'(req_valid), 32'(exp_req_v));
    if (exp_req_v) chk("req_addr", req_addr, exp_req_pc);
    chk("id_valid", 32'(id_valid), 32'(exp_id_v));
    if (exp_id_v) begin
      chk("id_pc", id_pc, live_q[0].pc);
      chk("id_instr", id_instr, mem_word(live_q[0].pc));
    end
    chk("wrap_req_valid", 32'(w_req_valid), 32'(exp_w_v));
    if (exp_w_v) chk("wrap_req_addr", w_req_addr, w_pc);
    chk("wrap_id_valid", 32'(w_id_valid), 32'h0);

    if (rst) begin
      pend.delete();
      live_q.delete();
      epoch++;
      exp_req_pc = 32'h0;
      w_n  = 0;
      w_pc = WRAP_PC;
    end else begin
      if (exp_w_v) begin
        if (w_log.size() < 3) w_log.push_back(w_req_addr);
        w_n++;
        w_pc += 32'd4;
      end
      if (rsp_valid) begin
        r = pend.pop_front();
        if (!redirect && r.epoch == epoch) begin
          for (int k = 0; k < live_q.size(); k++) begin
            if (!live_q[k].got) begin
              live_q[k].got = 1'b1;
              break;
            end
          end
        end
      end
      if (redirect) begin
        live_q.delete();
        epoch++;
        exp_req_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_req_v && req_ready) begin
          pend.push_back('{addr: exp_req_pc, due: cyc + lat, epoch: epoch});
          live_q.push_back('{pc: exp_req_pc, got: 1'b0});
          req_log.push_back(req_addr);
          exp_req_pc += 32'd4;
        end
        if (exp_id_v && id_ready) begin
          pop_log.push_back(id_pc);
          pop_cyc.push_back(32'(cyc));
          void'(live_q.pop_front());
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    exp_req_pc = 32'h0; w_pc = WRAP_PC;
    @(negedge clk);

    // Streaming from reset with 1-cycle memory
    step(); step(); rst = 1'b0;
    p0 = pop_log.size();
    repeat (8) step();
    chk("r035_pc0", at(pop_log, p0), 32'h0);
    chk("r035_pc1", at(pop_log, p0 + 1), 32'h4);
    chk("r035_pc2", at(pop_log, p0 + 2), 32'h8);
    chk("r035_consecutive", at(pop_cyc, p0 + 2) - at(pop_cyc, p0), 32'd2);
    chk("r039_wrap0", at(w_log, 0), 32'hFFFF_FFF8);
    chk("r039_wrap1", at(w_log, 1), 32'hFFFF_FFFC);
    chk("r039_wrap2", at(w_log, 2), 32'h0);

    // Decode stall fills the queue, then drains in order
    rst = 1'b1; step(); rst = 1'b0;
    id_ready = 1'b0;
    n0 = req_log.size(); p0 = pop_log.size();
    repeat (10) step();
    chk("r036_reqs_stalled", 32'(req_log.size() - n0), 32'd4);
    id_ready = 1'b1;
    repeat (10) step();
    chk("r036_pop0", at(pop_log, p0), 32'h0);
    chk("r036_pop1", at(pop_log, p0 + 1), 32'h4);
    chk("r036_pop2", at(pop_log, p0 + 2), 32'h8);
    chk("r036_pop3", at(pop_log, p0 + 3), 32'hC);
    chk("r036_resume", at(req_log, n0 + 4), 32'h10);

    // Redirect to an unaligned target with two requests in flight
    lat = 3;
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    n0 = req_log.size(); p0 = pop_log.size();
    redirect = 1'b1; redirect_pc = 32'h103; step(); redirect = 1'b0;
    chk("r037_drop_cnt", 32'(u_dut.drop_cnt), 32'd2);
    repeat (12) step();
    chk("r037_first_req", at(req_log, n0), 32'h100);
    chk("r037_first_pop", at(pop_log, p0), 32'h100);

    // Response and redirect in the same cycle, 3-cycle memory
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h208; step(); redirect = 1'b0;
    chk("r038_drop_mid", 32'(u_dut.drop_cnt), 32'd2);
    repeat (12) step();
    chk("r038_drop_end", 32'(u_dut.drop_cnt), 32'd0);

    // Back-to-back redirects: last target wins
    lat = 4;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h300; step();
    redirect_pc = 32'h405; step(); redirect = 1'b0;
    n0 = req_log.size();
    chk("r029_drop_acc", 32'(u_dut.drop_cnt), 32'd2);
    repeat (12) step();
    chk("r029_target", at(req_log, n0), 32'h404);

    // Reset with a full queue and responses in flight
    lat = 2;
    rst = 1'b1; step(); rst = 1'b0;
    id_ready = 1'b0;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    id_ready = 1'b1;
    n0 = req_log.size();
    repeat (6) step();
    chk("r040_first_req", at(req_log, n0), 32'h0);

    // Random traffic
    rst = 1'b1; step(); rst = 1'b0;
    repeat (1500) begin
      req_ready   = ($urandom_range(0, 3) != 0);
      id_ready    = ($urandom_range(0, 2) != 0);
      lat         = $urandom_range(1, 4);
      rst         = ($urandom_range(0, 299) == 0);
      redirect    = !rst && ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      step();
    end
    rst = 1'b0; redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
